// File: rtl/ccip_tx_almfull_buffer.sv
// Elastic CCI-P Tx request buffer: fire-and-forget AFU pushes throttled by almost-full,
// drained to the emulator through a first-word-fall-through valid/ready output register.
module ccip_tx_almfull_buffer #(
  parameter int DEPTH         = 64,
  parameter int HDR_W         = 80,
  parameter int DATA_W        = 512,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                     vl_clk_LPdomain_16ui,
  input  logic                     ffs_vl_LP32ui_lp2sy_SystemReset,
  input  logic                     afu_tx_valid,
  input  logic [HDR_W-1:0]         afu_tx_hdr,
  input  logic [DATA_W-1:0]        afu_tx_data,
  output logic                     afu_tx_almfull,
  output logic                     emu_tx_valid,
  output logic [HDR_W-1:0]         emu_tx_hdr,
  output logic [DATA_W-1:0]        emu_tx_data,
  input  logic                     emu_tx_ready,
  output logic                     overflow_err,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int RAM_D = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PW    = $clog2(RAM_D);

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic clk;
  logic rst;
  assign clk = vl_clk_LPdomain_16ui;
  assign rst = ffs_vl_LP32ui_lp2sy_SystemReset;

  req_t          mem [RAM_D];
  req_t          out_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] ram_cnt, ram_cnt_next, cnt_next;
  logic          pop, push, ram_empty, load_out, ram_rd, ram_wr, bypass;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAM_D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop          = emu_tx_valid & emu_tx_ready;
    push         = afu_tx_valid & ((fill_count < CW'(DEPTH)) | pop);
    ram_empty    = (ram_cnt == '0);
    // The output register may take a new head whenever it is empty or being popped.
    load_out     = ~emu_tx_valid | pop;
    ram_rd       = load_out & ~ram_empty;
    bypass       = push & load_out & ram_empty;
    ram_wr       = push & ~bypass;
    cnt_next     = fill_count + CW'(push) - CW'(pop);
    ram_cnt_next = ram_cnt + CW'(ram_wr) - CW'(ram_rd);
  end

  // NOTE: payload storage has no reset; only pointers and counts define what is valid,
  // so stale RAM contents can never surface and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= '{hdr: afu_tx_hdr, data: afu_tx_data};
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_cnt        <= '0;
      fill_count     <= '0;
      afu_tx_almfull <= 1'b0;
      emu_tx_valid   <= 1'b0;
      out_q          <= '0;
      overflow_err   <= 1'b0;
    end else begin
      if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
      ram_cnt        <= ram_cnt_next;
      fill_count     <= cnt_next;
      afu_tx_almfull <= (cnt_next >= CW'(DEPTH - ALMFULL_SLACK));
      if (afu_tx_valid && !push) overflow_err <= 1'b1;
      if (load_out) begin
        if (ram_rd) begin
          out_q        <= mem[rd_ptr];
          emu_tx_valid <= 1'b1;
        end else if (bypass) begin
          out_q        <= '{hdr: afu_tx_hdr, data: afu_tx_data};
          emu_tx_valid <= 1'b1;
        end else begin
          emu_tx_valid <= 1'b0;
        end
      end
    end
  end

  assign emu_tx_hdr  = out_q.hdr;
  assign emu_tx_data = out_q.data;

  // Simulation checks on configuration and on undriven control inputs.
  a_depth_pow2 : assert property (@(posedge clk) ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 4));
  a_slack_rng  : assert property (@(posedge clk) (ALMFULL_SLACK >= 1) && (ALMFULL_SLACK <= DEPTH - 2));
  a_ctrl_known : assert property (@(posedge clk) disable iff (rst)
                                  !$isunknown(afu_tx_valid) && !$isunknown(emu_tx_ready));

endmodule

// File: tb/tb_ccip_tx_almfull_buffer.sv
// Randomized bench for ccip_tx_almfull_buffer against a queue-based model of the
// buffer contents, sticky overflow and almost-full threshold.
module tb_ccip_tx_almfull_buffer;

  localparam int DEPTH         = 64;
  localparam int HDR_W         = 80;
  localparam int DATA_W        = 512;
  localparam int ALMFULL_SLACK = 8;
  localparam int CW            = $clog2(DEPTH) + 1;
  localparam int REQ_W         = HDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              afu_tx_valid = 1'b0;
  logic [HDR_W-1:0]  afu_tx_hdr = '0;
  logic [DATA_W-1:0] afu_tx_data = '0;
  logic              afu_tx_almfull;
  logic              emu_tx_valid;
  logic [HDR_W-1:0]  emu_tx_hdr;
  logic [DATA_W-1:0] emu_tx_data;
  logic              emu_tx_ready = 1'b0;
  logic              overflow_err;
  logic [CW-1:0]     fill_count;

  ccip_tx_almfull_buffer #(
    .DEPTH(DEPTH), .HDR_W(HDR_W), .DATA_W(DATA_W), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) dut (
    .vl_clk_LPdomain_16ui            (clk),
    .ffs_vl_LP32ui_lp2sy_SystemReset (rst),
    .afu_tx_valid                    (afu_tx_valid),
    .afu_tx_hdr                      (afu_tx_hdr),
    .afu_tx_data                     (afu_tx_data),
    .afu_tx_almfull                  (afu_tx_almfull),
    .emu_tx_valid                    (emu_tx_valid),
    .emu_tx_hdr                      (emu_tx_hdr),
    .emu_tx_data                     (emu_tx_data),
    .emu_tx_ready                    (emu_tx_ready),
    .overflow_err                    (overflow_err),
    .fill_count                      (fill_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the queue holds every accepted request in order, output stage included.
  logic [REQ_W-1:0] model_q[$];
  logic             model_ovf = 1'b0;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [HDR_W-1:0] rand_hdr();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[HDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] x;
    for (int i = 0; i < DATA_W / 32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic compare_all();
    int sz;
    sz = model_q.size();
    check("emu_tx_valid", 640'(emu_tx_valid), 640'(sz != 0));
    if (sz != 0) check("head", 640'({emu_tx_hdr, emu_tx_data}), 640'(model_q[0]));
    check("fill_count", 640'(fill_count), 640'(sz));
    check("afu_tx_almfull", 640'(afu_tx_almfull), 640'(sz >= DEPTH - ALMFULL_SLACK));
    check("overflow_err", 640'(overflow_err), 640'(model_ovf));
  endtask

  // One clock: drive at the falling edge, apply the model rules, compare after the rise.
  task automatic step(input logic v, input logic [HDR_W-1:0] h, input logic [DATA_W-1:0] d,
                      input logic r);
    bit pop, push;
    @(negedge clk);
    afu_tx_valid = v;
    afu_tx_hdr   = h;
    afu_tx_data  = d;
    emu_tx_ready = r;
    pop  = (model_q.size() > 0) && r;
    push = v && ((model_q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) void'(model_q.pop_front());
    if (push) model_q.push_back({h, d});
    if (v && !push) model_ovf = 1'b1;
    compare_all();
  endtask

  task automatic push_one(input logic r);
    step(1'b1, rand_hdr(), rand_data(), r);
  endtask

  task automatic idle(input logic r);
    step(1'b0, rand_hdr(), rand_data(), r);
  endtask

  task automatic mid_cycle_reset();
    @(negedge clk);
    afu_tx_valid = 1'b0;
    emu_tx_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    compare_all();
    check("rst_hdr", 640'(emu_tx_hdr), 640'(0));
    check("rst_data", 640'(emu_tx_data), 640'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Power-on reset state.
    #3;
    compare_all();
    check("rst_hdr", 640'(emu_tx_hdr), 640'(0));
    check("rst_data", 640'(emu_tx_data), 640'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request with 1-cycle fall-through, then consumed.
    step(1'b1, HDR_W'(1), {(DATA_W/8){8'hAA}}, 1'b1);
    check("first_hdr", 640'(emu_tx_hdr), 640'(1));
    idle(1'b1);
    check("drained", 640'(fill_count), 640'(0));

    // Stall the consumer and fill up to the threshold, then to full, then overrun.
    for (int i = 0; i < DEPTH - ALMFULL_SLACK; i++) push_one(1'b0);
    check("almfull_at_thresh", 640'(afu_tx_almfull), 640'(1));
    for (int i = 0; i < ALMFULL_SLACK; i++) push_one(1'b0);
    check("full_no_ovf", 640'(overflow_err), 640'(0));
    push_one(1'b0);
    check("drop_ovf", 640'(overflow_err), 640'(1));
    check("drop_fill", 640'(fill_count), 640'(DEPTH));
    idle(1'b0);

    // Full with simultaneous push and pop every cycle.
    for (int i = 0; i < 100; i++) push_one(1'b1);

    // Drain across the almost-full threshold, then down to 20 entries.
    while (model_q.size() > DEPTH - ALMFULL_SLACK) idle(1'b1);
    idle(1'b1);
    check("almfull_release", 640'(afu_tx_almfull), 640'(0));
    while (model_q.size() > 20) idle(1'b1);

    // Asynchronous reset mid-stream discards everything.
    mid_cycle_reset();
    idle(1'b1);
    idle(1'b1);
    push_one(1'b0);
    check("post_rst_valid", 640'(emu_tx_valid), 640'(1));

    // Random traffic from an AFU that respects almost-full.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 1) == 1) && !afu_tx_almfull, rand_hdr(), rand_data(),
           $urandom_range(0, 9) < 3);
    end
    check("random_no_ovf", 640'(overflow_err), 640'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
